// File: rtl/rect_fill_engine.sv
// Rectangle fill engine for a 1-bpp byte-wide frame buffer.
// Clips the rectangle, then blind-writes full bytes and read-modify-writes edge bytes.
module rect_fill_engine #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int AW     = 13
) (
  input  logic          uclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   x,
  input  logic [15:0]   y,
  input  logic [15:0]   w,
  input  logic [15:0]   h,
  input  logic          color,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          fb_gnt,
  output logic [AW-1:0] fb_addr,
  output logic          fb_rd,
  input  logic [7:0]    fb_rdata,
  output logic          fb_wr,
  output logic [7:0]    fb_wdata
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = XW - 3;

  localparam logic [15:0]   W16    = 16'(WIDTH);
  localparam logic [15:0]   H16    = 16'(HEIGHT);
  localparam logic [16:0]   W17    = 17'(WIDTH);
  localparam logic [16:0]   H17    = 17'(HEIGHT);
  localparam logic [XW-1:0] XMAX   = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X1     = XW'(1);
  localparam logic [YW-1:0] YMAX   = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y1     = YW'(1);
  localparam logic [CW-1:0] C1     = CW'(1);
  localparam logic [AW-1:0] STRIDE = AW'(WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ROW, S_RD, S_RWAIT, S_WR, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [15:0]   w_q, w_d, h_q, h_d;
  logic          color_q, color_d;
  logic          err_q, err_d;
  logic [XW-1:0] xl_q, xl_d;
  logic [YW-1:0] yl_q, yl_d;
  logic [YW-1:0] row_q, row_d;
  logic [CW-1:0] cb_q, cb_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    old_q, old_d;

  logic [16:0]   sx, sy;
  logic [7:0]    mask;
  logic [CW-1:0] cb_nx;
  logic          reject;

  // Bits lo..hi of byte c that fall inside columns xs..xl.
  function automatic logic [7:0] mask_of(
    input logic [CW-1:0] c,
    input logic [XW-1:0] xs,
    input logic [XW-1:0] xl
  );
    logic [2:0] lo, hi;
    lo = (c == xs[XW-1:3]) ? xs[2:0] : 3'd0;
    hi = (c == xl[XW-1:3]) ? xl[2:0] : 3'd7;
    return (8'hFF << lo) & (8'hFF >> (3'd7 - hi));
  endfunction

  assign sx     = {1'b0, x_q} + {1'b0, w_q};
  assign sy     = {1'b0, y_q} + {1'b0, h_q};
  assign reject = (x_q >= W16) || (y_q >= H16) ||
                  (w_q == 16'd0) || (h_q == 16'd0);
  assign mask   = mask_of(cb_q, x_q[XW-1:0], xl_q);
  assign cb_nx  = cb_q + C1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    err_d   = err_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    row_d   = row_q;
    cb_d    = cb_q;
    base_d  = base_q;
    old_d   = old_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          w_d     = w;
          h_d     = h;
          color_d = color;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          xl_d    = (sx >= W17) ? XMAX
                  : x_q[XW-1:0] + w_q[XW-1:0] - X1;
          yl_d    = (sy >= H17) ? YMAX
                  : y_q[YW-1:0] + h_q[YW-1:0] - Y1;
          row_d   = y_q[YW-1:0];
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        cb_d    = x_q[XW-1:3];
        base_d  = AW'(row_q) * STRIDE;
        state_d = (mask_of(x_q[XW-1:3], x_q[XW-1:0], xl_q) == 8'hFF)
                ? S_WR : S_RD;
      end
      S_RD: begin
        if (fb_gnt) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        old_d   = fb_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        if (fb_gnt) begin
          if (cb_q == xl_q[XW-1:3]) begin
            if (row_q == yl_q) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + Y1;
              state_d = S_ROW;
            end
          end else begin
            cb_d    = cb_nx;
            state_d = (mask_of(cb_nx, x_q[XW-1:0], xl_q) == 8'hFF)
                    ? S_WR : S_RD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= 1'b0;
      err_q   <= 1'b0;
      xl_q    <= '0;
      yl_q    <= '0;
      row_q   <= '0;
      cb_q    <= '0;
      base_q  <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      err_q   <= err_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      row_q   <= row_d;
      cb_q    <= cb_d;
      base_q  <= base_d;
      old_q   <= old_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign fb_rd    = (state_q == S_RD);
  assign fb_wr    = (state_q == S_WR);
  assign fb_addr  = (fb_rd || fb_wr) ? base_q + AW'(cb_q) : '0;
  assign fb_wdata = !fb_wr           ? 8'h00
                  : (mask == 8'hFF)  ? {8{color_q}}
                  : color_q          ? (old_q | mask)
                  :                    (old_q & ~mask);

endmodule
